// File: rtl/debounce_tick_if.sv
// Button-path bundle for debounce_tick: raw buttons in, divided clock/tick and
// clean levels/edges out. The slave side is the debouncer itself.
interface debounce_tick_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_in;
  logic               clk_1ms;
  logic               tick_1ms;
  logic [NUM_BTN-1:0] btn_out;
  logic [NUM_BTN-1:0] btn_rise;

  modport master (
    output btn_in,
    input  clk_1ms, tick_1ms, btn_out, btn_rise
  );

  modport slave (
    input  btn_in,
    output clk_1ms, tick_1ms, btn_out, btn_rise
  );
endinterface

// File: rtl/debounce_tick.sv
// Clock divider (square wave + strobe) and tick-sampled push-button debouncer.
// Optional macro DEBOUNCE_EDGE_EN enables registered rising-edge pulses on btn_rise.
module debounce_tick #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_BTN     = 4,
  parameter int SAMPLES     = 8
) (
  input logic clk,
  input logic rst_n,
  debounce_tick_if.slave bus
);

  localparam int HALF = CLK_FREQ_HZ / (2 * TICK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0]      cnt;
  logic               clk_1ms_q;
  logic               tick_q;
  logic               wrap;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [SAMPLES-1:0] shreg [NUM_BTN];
  logic [NUM_BTN-1:0] all_one;
  logic [NUM_BTN-1:0] all_zero;
  logic [NUM_BTN-1:0] btn_out_q;

  assign wrap = (cnt == LAST);

  // tick is raised on the same edge that flips clk_1ms from 0 to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      clk_1ms_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      if (wrap) begin
        cnt       <= '0;
        clk_1ms_q <= ~clk_1ms_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
      tick_q <= wrap & ~clk_1ms_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) shreg[i] <= '0;
    end else if (tick_q) begin
      for (int i = 0; i < NUM_BTN; i++) shreg[i] <= {shreg[i][SAMPLES-2:0], sync2[i]};
    end
  end

  always_comb begin
    all_one  = '0;
    all_zero = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      all_one[i]  = &shreg[i];
      all_zero[i] = ~|shreg[i];
    end
  end

  // mixed history holds the previous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_out_q <= '0;
    else        btn_out_q <= (btn_out_q | all_one) & ~all_zero;
  end

  assign bus.clk_1ms  = clk_1ms_q;
  assign bus.tick_1ms = tick_q;
  assign bus.btn_out  = btn_out_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [NUM_BTN-1:0] btn_out_d;
  logic [NUM_BTN-1:0] rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_out_d <= '0;
      rise_q    <= '0;
    end else begin
      btn_out_d <= btn_out_q;
      rise_q    <= btn_out_q & ~btn_out_d;
    end
  end

  assign bus.btn_rise = rise_q;
`else
  assign bus.btn_rise = '0;
`endif

endmodule

// File: tb/tb_debounce_tick.sv
// Scoreboard bench for debounce_tick: per-cycle expectations from a run-length
// model are queued by the stimulus process and popped by an independent monitor.
module tb_debounce_tick;

  localparam int CLK_FREQ_HZ = 20000;
  localparam int TICK_HZ     = 1000;
  localparam int NUM_BTN     = 4;
  localparam int SAMPLES     = 4;
  localparam int HALF        = CLK_FREQ_HZ / (2 * TICK_HZ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  debounce_tick_if #(.NUM_BTN(NUM_BTN)) bus ();

  debounce_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ    (TICK_HZ),
    .NUM_BTN    (NUM_BTN),
    .SAMPLES    (SAMPLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic               ck;
    logic               tk;
    logic [NUM_BTN-1:0] out;
    logic [NUM_BTN-1:0] rise;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   k;

  logic [NUM_BTN-1:0] in_hist  [int];
  logic [NUM_BTN-1:0] lvl_hist [int];
  logic [NUM_BTN-1:0] out_hist [int];
  logic [NUM_BTN-1:0] run_val;
  logic [NUM_BTN-1:0] level;
  int                 run_len [NUM_BTN];

  // Reference: a level is adopted once SAMPLES consecutive tick samples agree;
  // reset counts as a full run of zeros.
  task automatic model_reset();
    in_hist.delete();
    lvl_hist.delete();
    out_hist.delete();
    run_val = '0;
    level   = '0;
    for (int i = 0; i < NUM_BTN; i++) run_len[i] = SAMPLES;
    k = 0;
  endtask

  task automatic push_cycle(input logic [NUM_BTN-1:0] v);
    exp_t               e;
    logic               tk;
    logic [NUM_BTN-1:0] smp;
    logic [NUM_BTN-1:0] out;
    logic [NUM_BTN-1:0] rise;
    bus.btn_in = v;
    in_hist[k] = v;
    tk = (k >= HALF) && (((k - HALF) % (2 * HALF)) == 0);
    if (tk) begin
      // the tick sees the input two cycles old (synchronizer depth)
      smp = (k >= 2) ? in_hist[k-2] : '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (smp[i] == run_val[i]) begin
          if (run_len[i] < SAMPLES) run_len[i]++;
        end else begin
          run_val[i] = smp[i];
          run_len[i] = 1;
        end
        if (run_len[i] >= SAMPLES) level[i] = run_val[i];
      end
    end
    lvl_hist[k] = level;
    out = (k >= 2) ? lvl_hist[k-2] : '0;
    out_hist[k] = out;
`ifdef DEBOUNCE_EDGE_EN
    rise = (k >= 2) ? (out_hist[k-1] & ~out_hist[k-2]) : '0;
`else
    rise = '0;
`endif
    e.cyc  = k;
    e.ck   = ((k / HALF) % 2) == 1;
    e.tk   = tk;
    e.out  = out;
    e.rise = rise;
    sb_q.push_back(e);
  endtask

  task automatic release_rst(input logic [NUM_BTN-1:0] v);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    push_cycle(v);
  endtask

  task automatic step(input logic [NUM_BTN-1:0] v);
    @(posedge clk);
    #1;
    k++;
    push_cycle(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.clk_1ms, bus.tick_1ms, bus.btn_out, bus.btn_rise});
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({bus.clk_1ms, bus.tick_1ms, bus.btn_out, bus.btn_rise} !== {e.ck, e.tk, e.out, e.rise}) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d got ck=%b tk=%b out=%b rise=%b expected ck=%b tk=%b out=%b rise=%b",
                   e.cyc, bus.clk_1ms, bus.tick_1ms, bus.btn_out, bus.btn_rise, e.ck, e.tk, e.out, e.rise);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [NUM_BTN-1:0] cur;
    logic [NUM_BTN-1:0] drv;
    bus.btn_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", all_outs(), 32'h0);

    // btn0 clean press, btn1 flips level every tick, btn2 pressed, btn3 idle
    release_rst(4'b0101);
    for (int c = 1; c < 200; c++) step({1'b0, 1'b1, 1'(((c / 20) % 2)), 1'b1});
    check("press_btn0", 32'(bus.btn_out[0]), 32'h1);
    check("bounce_btn1", 32'(bus.btn_out[1]), 32'h0);

    // btn1 settles high, btn3 pressed
    for (int c = 0; c < 200; c++) step(4'b1111);
    check("settle_all", 32'(bus.btn_out), 32'hf);

    // btn2/btn3 released; btn2 gets exactly one high sample mid-release
    for (int c = 0; c < 40; c++)  step(4'b0011);
    for (int c = 0; c < 20; c++)  step(4'b0111);
    for (int c = 0; c < 200; c++) step(4'b0011);
    check("release_btn2", 32'(bus.btn_out), 32'h3);

    for (int c = 0; c < 200; c++) step(4'b1111);
    check("pre_reset_all", 32'(bus.btn_out), 32'hf);

    // asynchronous reset in the middle of a clock-high phase
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset_now", all_outs(), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("async_reset_held", all_outs(), 32'h0);

    release_rst(4'b1111);
    for (int c = 1; c < 200; c++) step(4'b1111);
    check("requalified", 32'(bus.btn_out), 32'hf);

    // random levels with occasional one-cycle glitches
    cur = 4'(bus.btn_out);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if ($urandom_range(0, 29) == 0) cur[i] = ~cur[i];
      end
      drv = cur;
      if ($urandom_range(0, 49) == 0) drv = cur ^ 4'($urandom_range(1, 15));
      step(drv);
    end

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_tick.md
Name: debounce_tick

Overview:
- Timing-and-input front end for the player-movement logic.
- Divides the system clock down to a 1 ms square wave and a single-cycle 1 ms strobe.
- Debounces NUM_BTN push-button inputs, sampling them on that strobe.
- Provides the clean direction levels and the 1 ms movement clock consumed by the player movers.

Parameters:
- CLK_FREQ_HZ, 50000000: frequency of clk in Hz.
- TICK_HZ, 1000: output tick rate in Hz; 1000 gives 1 ms.
- NUM_BTN, 4: number of independent button channels.
- SAMPLES, 8: consecutive equal tick samples needed to change a debounced output; legal range 2..16.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_in, input, NUM_BTN: raw, asynchronous, bouncing button levels; active high.
- clk_1ms, output, 1: divided square wave, 50% duty, period 1/TICK_HZ.
- tick_1ms, output, 1: one-clk-cycle pulse coincident with each rising edge of clk_1ms.
- btn_out, output, NUM_BTN: debounced button levels, active high.
- btn_rise, output, NUM_BTN: one-clk-cycle pulse on each debounced 0->1 transition; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous): the following all clear to 0 immediately and remain 0 while reset is held:
  - divider counter, clk_1ms, tick_1ms;
  - synchronizer flops, every shift register;
  - btn_out, btn_rise.
- Divider:
  - HALF = CLK_FREQ_HZ/(2*TICK_HZ), integer division; HALF >= 1 is required.
  - Counter width is clog2(HALF), minimum 1 bit.
  - Counter increments every clk. When it equals HALF-1 it wraps to 0 and clk_1ms toggles.
  - tick_1ms is registered. It is 1 for exactly the clk cycle in which clk_1ms is 1 for its first cycle after a 0->1 toggle.
  - After reset release, the first clk_1ms rise is at clk edge HALF, the first tick_1ms pulse is in cycle HALF, and ticks then repeat every 2*HALF cycles.
- Synchronizer: each btn_in bit passes through two flops (sync) before any use.
- Debounce, per channel:
  - On every cycle with tick_1ms=1, shreg <= {shreg[SAMPLES-2:0], sync}. Otherwise shreg holds.
  - btn_out is evaluated every clk: it becomes 1 when shreg is all ones, becomes 0 when shreg is all zeros, and holds otherwise.
  - Latency: a clean level change is reflected at btn_out 1 clk after the SAMPLES-th tick that samples the new level.
  - Bounce shorter than SAMPLES ticks never changes btn_out.
- Channels are fully independent. Simultaneous changes on several buttons are each handled on their own.
- A glitch wholly between two ticks is invisible.
- Reset mid-operation discards all history. After release, btn_out stays 0 until SAMPLES ticks of high input have been sampled.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN.
- Defined:
  - btn_rise[i] is a registered pulse of 1 clk, asserted in the cycle after btn_out[i] goes 0->1.
  - There is no pulse on 1->0 transitions, and none while or immediately after reset.
- Undefined:
  - btn_rise is still present as a port, tied constant 0.
  - No edge-detect flops are synthesized.

Test Plan:
- Tick rate: CLK_FREQ_HZ=20000, TICK_HZ=1000 (HALF=10); release reset -> clk_1ms toggles every 10 cycles; tick_1ms high in cycles 10, 30, 50 only.
- Clean press: SAMPLES=4, btn_in[0] held 1 from cycle 0 -> btn_out[0] rises 1 clk after the 4th tick that samples high; it stays 0 before that point.
- Bounce rejection: SAMPLES=4, btn_in[1] alternates level every tick for 10 ticks -> btn_out[1] stays 0. Then hold 1 -> btn_out[1] rises after 4 high samples.
- Release: after btn_out[2]=1, drop btn_in[2] to 0 -> btn_out[2] falls after 4 low samples. A single high sample in the middle of the release restarts the count.
- Async reset: assert rst_n=0 mid-count with btn_out=4'b1111 -> all outputs 0 immediately, without waiting for clk. After release, outputs return only after full re-qualification.
- With DEBOUNCE_EDGE_EN: on the clean press of btn_in[3] -> btn_rise[3] is high for exactly 1 cycle, the cycle after btn_out[3] rises; no pulse on release. Without the macro, btn_rise stays 4'b0000 throughout.
